irq_req_latch: RTL and testbench
================================

// Module: irq_req_latch
// PURPOSE
//  Upstream request stage for the 4-to-2 encoder.
//  - Captures rising edges on N asynchronous-to-software request lines into sticky pending bits.
//  - Applies a mask and picks one request round-robin.
//  - Presents the choice as a stable one-hot vector plus valid: grant_onehot drives encoder in, grant_valid drives EIN.
//  - Holds the grant until the downstream consumer acknowledges it.
// PARAMETERS
//  N        4   number of request lines (encoder consumer requires 4)
//  PTR_W    2   width of round-robin pointer, = clog2(N)
// PORTS
//  clk           in   1      rising-edge clock
//  rst           in   1      synchronous, active-high reset
//  req           in   N      request lines, already synchronised to clk
//  mask          in   N      1 = line masked (still latched, never granted)
//  grant_onehot  out  N      one-hot selected line; 0 when grant_valid=0
//  grant_valid   out  1      grant_onehot holds a valid selection (to EIN)
//  grant_ready   in   1      consumer accepts current grant this cycle
//  pending       out  N      sticky pending bits, masked or not
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//  - pending, grant_onehot and grant_valid go to 0.
//  - req_q (previous req sample) goes to 0.
//  - rr_ptr goes to N-1, so line 0 has first priority.
//  - FSM goes to IDLE.
//  Edge detect:
//  - edge = req & ~req_q, registered every cycle.
//  - pending[i] sets on edge[i].
//  FSM states:
//  - IDLE:
//    - elig = pending & ~mask.
//    - If elig != 0, choose the first set bit scanning rr_ptr+1, rr_ptr+2, ... (mod N).
//    - Load grant_onehot with the choice, set grant_valid, go to OFFER.
//    - Otherwise stay in IDLE.
//  - OFFER:
//    - grant_onehot and grant_valid are held stable while grant_ready=0.
//    - Changing mask does not withdraw the grant.
//    - On grant_ready=1: clear the granted pending bit, set rr_ptr to the granted index.
//    - In the same cycle: grant_valid goes to 0, grant_onehot goes to 0, FSM returns to IDLE.
//  Latency:
//  - req rises in cycle t; pending is visible at t+1; grant_valid is high at t+2, if the FSM is idle and the line is unmasked.
//  - Minimum spacing between back-to-back grants: 2 cycles (the ack cycle, then one IDLE selection cycle).
//  Boundary cases:
//  - New edge on the granted line in its ack cycle: set wins; pending stays 1 and the line re-arbitrates later.
//  - Repeated edges while already pending: absorbed, no count is kept.
//  - All eligible lines masked: stay in IDLE; pending is retained.
//  - rr_ptr wraps from N-1 to 0.
//  - grant_ready while in IDLE: ignored.
//  - rst mid-OFFER: grant dropped, all pending lost, next cycle is a clean IDLE.
//  Invariant: grant_onehot has exactly one bit set iff grant_valid=1, otherwise it is all zeros.
// CONFIGURATION
//  IRQ_LEVEL_EN
//  - Defined (level-sensitive mode):
//    - Edge detect is bypassed and req_q is unused.
//    - pending[i] sets on every cycle in which req[i]=1.
//    - An ack of a line whose req is still high leaves pending set, so the line is re-granted after other eligible lines.
//  - Undefined: edge-sensitive behaviour as above.
// TESTING
//  1. Reset: rst=1 for 2 cycles, req=4'b1111 -> grant_valid=0, pending=0 throughout; after release, edges needed before any grant.
//  2. Single request: req 0->4'b0100 at t, mask=0, grant_ready=1 -> grant_onehot=4'b0100 and grant_valid=1 at t+2; pending=0 at t+3.
//  3. Round-robin: pending=4'b1011 in one cycle, grant_ready held 1 -> grants 0001, 0010, 1000, each 2 cycles apart, then idle.
//  4. Hold/mask: grant 4'b0010 offered with grant_ready=0 for 5 cycles, mask=4'b0010 applied mid-offer -> grant unchanged until ack.
//  5. Simultaneous clear/set: ack of 4'b0001 in the same cycle as a new rising edge on req[0] -> pending[0] remains 1 and is re-granted.
//  6. IRQ_LEVEL_EN: req=4'b0001 held high -> line 0 is re-granted every 2 cycles; without the macro it is granted once.

Source files
------------

// File: rtl/irq_req_latch_if.sv
// Bundle of request, grant and pending signals between requesters and irq_req_latch.
// Ports: req, mask, grant_ready (into the latch); grant_onehot, grant_valid, pending (out of it).
// master = requester/consumer side, slave = irq_req_latch side.
interface irq_req_latch_if #(
  parameter int N = 4
);
  logic [N-1:0] req;
  logic [N-1:0] mask;
  logic [N-1:0] grant_onehot;
  logic         grant_valid;
  logic         grant_ready;
  logic [N-1:0] pending;

  modport master (
    output req, mask, grant_ready,
    input  grant_onehot, grant_valid, pending
  );

  modport slave (
    input  req, mask, grant_ready,
    output grant_onehot, grant_valid, pending
  );
endinterface

// File: rtl/irq_req_latch.sv
// Purpose: latch request edges into sticky pending bits, pick one unmasked line round-robin
//          and offer it as a held one-hot grant until the consumer acknowledges it.
// Ports:   clk, rst (sync, active-high); bus (irq_req_latch_if.slave): req, mask, grant_ready in;
//          grant_onehot, grant_valid, pending out.
// Option:  define IRQ_LEVEL_EN for level-sensitive requests (pending follows req every cycle).
//
// Purpose: request edge capture + round-robin arbitration feeding the 4-to-2 encoder.
// Latency: req rise at t -> pending at t+1 -> grant_valid at t+2 (idle, unmasked line).
// Backpressure: grant held stable while grant_ready=0; ack frees the stage, next grant 2 cycles later.
module irq_req_latch #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input logic             clk,
  input logic             rst,
  irq_req_latch_if.slave  bus
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t             state, state_nxt;
  logic [N-1:0]       pending_q, pending_nxt;
  logic [N-1:0]       grant_q, grant_nxt;
  logic               valid_q, valid_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_nxt;
  logic [PTR_W-1:0]   gidx_q, gidx_nxt;
  logic [PTR_W-1:0]   cand;
  logic               found;
  logic [N-1:0]       set_vec;
  logic [N-1:0]       elig;

`ifdef IRQ_LEVEL_EN
  // Level mode: an asserted line keeps re-arming its pending bit.
  assign set_vec = bus.req;
`else
  logic [N-1:0] req_q;

  always_ff @(posedge clk) begin
    if (rst) req_q <= '0;
    else     req_q <= bus.req;
  end

  assign set_vec = bus.req & ~req_q;
`endif

  // Masked lines stay pending but are invisible to arbitration.
  assign elig = pending_q & ~bus.mask;

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending_q | set_vec;
    grant_nxt   = grant_q;
    valid_nxt   = valid_q;
    rr_nxt      = rr_ptr;
    gidx_nxt    = gidx_q;
    found       = 1'b0;
    cand        = '0;

    case (state)
      IDLE: begin
        // Scan starts one past the last granted line so every line gets a turn.
        for (int k = 1; k <= N; k++) begin
          cand = PTR_W'((int'(rr_ptr) + k) % N);
          if (!found && elig[cand]) begin
            found    = 1'b1;
            gidx_nxt = cand;
          end
        end
        if (found) begin
          grant_nxt           = '0;
          grant_nxt[gidx_nxt] = 1'b1;
          valid_nxt           = 1'b1;
          state_nxt           = OFFER;
        end
      end

      OFFER: begin
        // Mask is deliberately ignored here: an offered grant is never withdrawn.
        if (bus.grant_ready) begin
          // Clear first, then OR in new sets, so an edge in the ack cycle survives.
          pending_nxt = (pending_q & ~grant_q) | set_vec;
          rr_nxt      = gidx_q;
          grant_nxt   = '0;
          valid_nxt   = 1'b0;
          state_nxt   = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending_q <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      rr_ptr    <= PTR_W'(N - 1);
      gidx_q    <= '0;
    end else begin
      state     <= state_nxt;
      pending_q <= pending_nxt;
      grant_q   <= grant_nxt;
      valid_q   <= valid_nxt;
      rr_ptr    <= rr_nxt;
      gidx_q    <= gidx_nxt;
    end
  end

  assign bus.grant_onehot = grant_q;
  assign bus.grant_valid  = valid_q;
  assign bus.pending      = pending_q;

endmodule

// File: tb/tb_irq_req_latch.sv
// Bench for irq_req_latch: directed vector table, hand sequences and randomized
// traffic compared against a cycle-level reference model.
module tb_irq_req_latch;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  irq_req_latch_if #(.N(N)) bus ();

  irq_req_latch #(.N(N), .PTR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: pending set, previous request sample, current offer, last winner.
  bit [N-1:0] m_pend;
  bit [N-1:0] m_prev;
  bit         m_gv;
  int         m_gidx;
  int         m_ptr;

  function automatic bit [N-1:0] m_go();
    bit [N-1:0] v;
    v = '0;
    if (m_gv) v[m_gidx] = 1'b1;
    return v;
  endfunction

  task automatic model_step(input bit r, input bit [N-1:0] rq, input bit [N-1:0] mk, input bit rd);
    bit [N-1:0] newset;
    if (r) begin
      m_pend = '0;
      m_prev = '0;
      m_gv   = 1'b0;
      m_gidx = 0;
      m_ptr  = N - 1;
    end else begin
`ifdef IRQ_LEVEL_EN
      newset = rq;
`else
      newset = rq & ~m_prev;
`endif
      if (m_gv) begin
        if (rd) begin
          m_pend[m_gidx] = 1'b0;
          m_ptr          = m_gidx;
          m_gv           = 1'b0;
        end
      end else begin
        for (int d = 1; d <= N; d++) begin
          int c;
          c = (m_ptr + d) % N;
          if (!m_gv && m_pend[c] && !mk[c]) begin
            m_gv   = 1'b1;
            m_gidx = c;
          end
        end
      end
      m_pend = m_pend | newset;
      m_prev = rq;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Drive one cycle's inputs, clock, advance the model, and land on the falling edge.
  task automatic cyc(input bit r, input logic [N-1:0] rq, input logic [N-1:0] mk, input bit rd);
    rst             = r;
    bus.req         = rq;
    bus.mask        = mk;
    bus.grant_ready = rd;
    @(posedge clk);
    model_step(r, rq, mk, rd);
    @(negedge clk);
  endtask

  typedef struct {
    bit           rst;
    logic [N-1:0] req;
    logic [N-1:0] mask;
    bit           rdy;
    logic [N-1:0] go;
    bit           gv;
    logic [N-1:0] pend;
  } vec_t;

  vec_t tbl[35];
  int   gcount;
  logic [N-1:0] rq_r;

  initial begin
    rst = 1'b1; bus.req = '0; bus.mask = '0; bus.grant_ready = 1'b0;

    //               rst  req      mask     rdy   go       gv    pend
    tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000};
    tbl[1]  = '{1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000};
    tbl[2]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000};
    tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000};
    // single request on line 2
    tbl[4]  = '{1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0100};
    tbl[5]  = '{1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 4'b0100};
    tbl[6]  = '{1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000};
    tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000};
    // round robin over 1011 from a fresh pointer
    tbl[8]  = '{1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000};
    tbl[9]  = '{1'b0, 4'b1011, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b1011};
    tbl[10] = '{1'b0, 4'b1011, 4'b0000, 1'b1, 4'b0001, 1'b1, 4'b1011};
    tbl[11] = '{1'b0, 4'b1011, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b1010};
    tbl[12] = '{1'b0, 4'b1011, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b1010};
    tbl[13] = '{1'b0, 4'b1011, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b1000};
    tbl[14] = '{1'b0, 4'b1011, 4'b0000, 1'b1, 4'b1000, 1'b1, 4'b1000};
    tbl[15] = '{1'b0, 4'b1011, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000};
    tbl[16] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000};
    // hold while not ready, mask applied mid-offer
    tbl[17] = '{1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0010};
    tbl[18] = '{1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 4'b0010};
    tbl[19] = '{1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 4'b0010};
    tbl[20] = '{1'b0, 4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 4'b0010};
    tbl[21] = '{1'b0, 4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 4'b0010};
    tbl[22] = '{1'b0, 4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 4'b0010};
    tbl[23] = '{1'b0, 4'b0010, 4'b0010, 1'b1, 4'b0000, 1'b0, 4'b0000};
    tbl[24] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000};
    // new edge on line 0 in its own ack cycle
    tbl[25] = '{1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0001};
    tbl[26] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b1, 4'b0001};
    tbl[27] = '{1'b0, 4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0001};
    tbl[28] = '{1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 4'b0001};
    tbl[29] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000};
    // reset in the middle of an offer, then ready while idle
    tbl[30] = '{1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0100};
    tbl[31] = '{1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 4'b0100};
    tbl[32] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000};
    tbl[33] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000};
    tbl[34] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000};

    @(negedge clk);

`ifndef IRQ_LEVEL_EN
    for (int i = 0; i < 35; i++) begin
      cyc(tbl[i].rst, tbl[i].req, tbl[i].mask, tbl[i].rdy);
      chk($sformatf("vec%0d grant_onehot", i), 32'(bus.grant_onehot), 32'(tbl[i].go));
      chk($sformatf("vec%0d grant_valid", i),  32'(bus.grant_valid),  32'(tbl[i].gv));
      chk($sformatf("vec%0d pending", i),      32'(bus.pending),      32'(tbl[i].pend));
    end
`endif

    // Held request on line 0: edge mode grants once, level mode every other cycle.
    cyc(1'b1, 4'b0000, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
    gcount = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 4'b0001, 4'b0000, 1'b1);
      if (bus.grant_valid === 1'b1) gcount++;
    end
`ifdef IRQ_LEVEL_EN
    chk("held_req grant count", 32'(gcount), 32'd4);
`else
    chk("held_req grant count", 32'(gcount), 32'd1);
`endif

    // Randomized traffic against the reference model.
    cyc(1'b1, 4'b0000, 4'b0000, 1'b0);
    rq_r = '0;
    for (int i = 0; i < 3000; i++) begin
      bit         r;
      logic [N-1:0] mk;
      bit         rd;
      r    = ($urandom_range(0, 99) == 0);
      rq_r = rq_r ^ (N'($urandom) & N'($urandom));
      mk   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      rd   = ($urandom_range(0, 2) != 0);
      cyc(r, rq_r, mk, rd);
      chk($sformatf("rnd%0d grant_onehot", i), 32'(bus.grant_onehot), 32'(m_go()));
      chk($sformatf("rnd%0d grant_valid", i),  32'(bus.grant_valid),  32'(m_gv));
      chk($sformatf("rnd%0d pending", i),      32'(bus.pending),      32'(m_pend));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
